// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
// Default geometry is 16 entries of 8 bits; the count is one bit wider than
// the pointer index so that both 0 and DEPTH can be represented.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_AF_MARGIN  = 2;
  localparam int DEFAULT_AE_MARGIN  = 2;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: DEPTH x DATA_WIDTH, one synchronous write
// port and one synchronous read port. The read data register is cleared by
// reset; the array itself is never cleared.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_BITS-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_BITS-1:0]  i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: array contents survive reset on purpose.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: when read and write hit the same address in one cycle the
  // old contents are returned, which is what lets a full FIFO read its
  // oldest word while overwriting that slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, full/empty,
// almost-full/almost-empty flags, occupancy count and error indications.
// Build option SYNC_FIFO_STICKY_ERR_EN: when defined, overflow/underflow
// stay set until reset; otherwise they are one-cycle pulses.
//
// Request semantics: wr_en and rd_en are requests, not handshakes held until
// served. A write is taken when the FIFO is not full, or when it is full and
// a read is taken in the same cycle. A read is taken whenever the FIFO is
// not empty; it never falls through a same-cycle write. A request that is
// not taken is dropped and reported on overflow/underflow the next cycle.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_BITS  = count_bits(DEPTH) - 1,
  parameter int AF_MARGIN  = DEFAULT_AF_MARGIN,
  parameter int AE_MARGIN  = DEFAULT_AE_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_BITS:0]    count
);

  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_AF   = (ADDR_BITS+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_BITS:0]   CNT_AE   = (ADDR_BITS+1)'(AE_MARGIN);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_overflow;
  logic                 r_underflow;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_accept;
  logic                 w_rd_accept;
  logic                 w_ovf_event;
  logic                 w_unf_event;

  // Status flags are decoded from the registered count only.
  assign w_full       = (r_count == CNT_FULL);
  assign w_empty      = (r_count == '0);
  assign almost_full  = (r_count >= CNT_AF);
  assign almost_empty = (r_count <= CNT_AE);
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;

  assign w_rd_accept = rd_en & ~w_empty;
  assign w_wr_accept = wr_en & (~w_full | w_rd_accept);
  assign w_ovf_event = wr_en & ~w_wr_accept;
  assign w_unf_event = rd_en & ~w_rd_accept;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_accept),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

  // Pointers advance on accepted transfers; DEPTH is a power of two so the
  // natural binary rollover provides the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: a simultaneous accepted read and write leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error indications for dropped requests, pulsed or sticky by build option.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
      r_overflow  <= r_overflow  | w_ovf_event;
      r_underflow <= r_underflow | w_unf_event;
`else
      r_overflow  <= w_ovf_event;
      r_underflow <= w_unf_event;
`endif
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo (DATA_WIDTH=8, DEPTH=16, default margins).
// A queue model of the FIFO contents predicts every accepted read; the
// predicted word is pushed to exp_q when the read is driven and popped and
// compared against rd_data once the DUT has produced it.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AB    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic [AB:0]   count;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .count        (count)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] model_q[$];  // words currently held by the FIFO
  logic [DW-1:0] exp_q[$];    // read results expected from the DUT
  logic [DW-1:0] exp_rd;      // value rd_data must hold
  logic          exp_ovf;
  logic          exp_unf;
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs at negedge, update the model, then check every
  // output 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic we, input logic [DW-1:0] wd, input logic re);
    logic wacc;
    logic racc;
    int   sz;
    @(negedge clk);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    sz   = model_q.size();
    racc = !r && re && (sz != 0);
    wacc = !r && we && ((sz != DEPTH) || racc);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    if (r) begin
      model_q.delete();
      exp_q.delete();
      exp_rd  = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
      exp_ovf = exp_ovf | (we && !wacc);
      exp_unf = exp_unf | (re && !racc);
`else
      exp_ovf = we && !wacc;
      exp_unf = re && !racc;
`endif
    end
    @(posedge clk);
    #1;
    if (racc) exp_rd = exp_q.pop_front();
    check("rd_data",      32'(rd_data),      32'(exp_rd));
    check("count",        32'(count),        32'(model_q.size()));
    check("empty",        32'(empty),        32'(model_q.size() == 0));
    check("full",         32'(full),         32'(model_q.size() == DEPTH));
    check("almost_full",  32'(almost_full),  32'(model_q.size() >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 2));
    check("overflow",     32'(overflow),     32'(exp_ovf));
    check("underflow",    32'(underflow),    32'(exp_unf));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;

    // 1 reset held for two cycles
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);

    // 2 fill to full, then one write too many
    for (int i = 1; i <= 16; i++) push(DW'(i));
    check("fill_full",  32'(full),        32'd1);
    check("fill_count", 32'(count),       32'd16);
    check("fill_af",    32'(almost_full), 32'd1);
    push(8'hAA);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    idle();

    // 3 drain in order, then one read too many
    for (int i = 1; i <= 16; i++) begin
      pop();
      check("drain_order", 32'(rd_data), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    pop();
    check("unf_set",     32'(underflow), 32'd1);
    check("unf_rd_hold", 32'(rd_data),   32'h10);
    idle();

    // 4 simultaneous write+read on empty, then on full
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    check("sim_empty_count", 32'(count),     32'd1);
    check("sim_empty_unf",   32'(underflow), 32'd1);
    pop();
    check("sim_empty_data", 32'(rd_data), 32'h55);
    for (int i = 0; i < 16; i++) push(DW'($urandom_range(0, 255)));
    cycle(1'b0, 1'b1, 8'h77, 1'b1);
    check("sim_full_count", 32'(count),    32'd16);
    check("sim_full_ovf",   32'(overflow), 32'd0);

    // 5 thresholds starting from one entry
    cycle(1'b1, 1'b0, '0, 1'b0);
    push(8'h3C);
    for (int i = 0; i < 13; i++) push(DW'($urandom_range(0, 255)));
    check("thr_count14", 32'(count),       32'd14);
    check("thr_af",      32'(almost_full), 32'd1);
    for (int i = 0; i < 13; i++) pop();
    check("thr_count1",  32'(count),        32'd1);
    check("thr_ae",      32'(almost_empty), 32'd1);

    // 6 reset in mid-operation overrides a same-cycle write
    for (int i = 0; i < 4; i++) push(DW'($urandom_range(0, 255)));
    check("pre_rst_count", 32'(count), 32'd5);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    idle();

    // wrap: interleaved traffic pushes both pointers around the array
    for (int i = 0; i < 3; i++) push(DW'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, DW'($urandom_range(0, 255)), 1'b1);
    while (model_q.size() != 0) pop();
    check("wrap_exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
